// File: rtl/psum_accum_ctrl.sv
// Partial-sum accumulation controller: aligns skewed mac-array column outputs into rows,
// accumulates them in the psum SRAM over num_pass passes, then streams rows with optional ReLU.
module psum_accum_ctrl #(
  parameter int COL        = 8,
  parameter int PSUM_BW    = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             num_pass,
  input  logic                   relu_en,
  input  logic [COL-1:0]         col_valid,
  input  logic [COL*PSUM_BW-1:0] col_data,
  input  logic [COL*PSUM_BW-1:0] sram_q,
  output logic [COL*PSUM_BW-1:0] sram_d,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic                   sram_cen,
  output logic                   sram_wen,
  output logic                   out_valid,
  output logic [COL*PSUM_BW-1:0] out_data,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int ROW_W = COL * PSUM_BW;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, ACC_FIRST, ACC_RD, ACC_WR, RO_RD, RO_WAIT, RO_HOLD, FIN
  } state_t;

  state_t            state;
  logic [3:0]        num_pass_q;
  logic [3:0]        pass;
  logic [3:0]        pass_inc;
  logic              relu_q;
  logic [ADDR_W-1:0] row;
  logic [ROW_W-1:0]  row_reg;
  logic [ROW_W-1:0]  fifo_row;
  logic [ROW_W-1:0]  sum_row;
  logic [ROW_W-1:0]  relu_row;
  logic [COL-1:0]    fifo_nonempty;
  logic [COL-1:0]    fifo_full;
  logic [COL-1:0]    push;
  logic [COL-1:0]    push_drop;
  logic              acc_phase;
  logic              row_avail;
  logic              pop;
  logic              err_set;

  assign acc_phase = (state == ACC_FIRST) || (state == ACC_RD) || (state == ACC_WR);
  assign row_avail = &fifo_nonempty;
  assign pop       = row_avail && ((state == ACC_FIRST) || (state == ACC_RD));
  assign push      = col_valid & {COL{acc_phase}};
  assign err_set   = (|push_drop) || (!acc_phase && (|col_valid));
  assign pass_inc  = pass + 4'd1;

  for (genvar i = 0; i < COL; i++) begin : g_fifo
    logic [PSUM_BW-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;

    assign fifo_full[i]     = (count == FULL_CNT);
    assign fifo_nonempty[i] = (count != '0);
    // A same-cycle pop frees a slot, so a push into a full FIFO is only lost without one.
    assign do_push      = push[i] && (!fifo_full[i] || pop);
    assign push_drop[i] = push[i] && fifo_full[i] && !pop;
    assign fifo_row[i*PSUM_BW +: PSUM_BW] = mem[rd_ptr];

    // NOTE: storage has no reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= col_data[i*PSUM_BW +: PSUM_BW];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
        if (pop)     rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
        if (do_push && !pop)      count <= count + CNT_W'(1);
        else if (!do_push && pop) count <= count - CNT_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < COL; i++) begin
      sum_row[i*PSUM_BW +: PSUM_BW]  = sram_q[i*PSUM_BW +: PSUM_BW] + row_reg[i*PSUM_BW +: PSUM_BW];
      relu_row[i*PSUM_BW +: PSUM_BW] = (relu_q && sram_q[i*PSUM_BW + PSUM_BW - 1]) ?
                                       '0 : sram_q[i*PSUM_BW +: PSUM_BW];
    end
  end

  // SRAM pins follow the current state so read data lands in the very next cycle,
  // which is what lets the read-modify-write close in two cycles.
  // NOTE: every output gets a default before the case, so no latch can be inferred.
  always_comb begin
    sram_cen  = 1'b1;
    sram_wen  = 1'b1;
    sram_addr = '0;
    sram_d    = '0;
    case (state)
      ACC_FIRST: if (row_avail) begin
        sram_cen  = 1'b0;
        sram_wen  = 1'b0;
        sram_addr = row;
        sram_d    = fifo_row;
      end
      ACC_RD: if (row_avail) begin
        sram_cen  = 1'b0;
        sram_addr = row;
      end
      ACC_WR: begin
        sram_cen  = 1'b0;
        sram_wen  = 1'b0;
        sram_addr = row;
        sram_d    = sum_row;
      end
      RO_RD: begin
        sram_cen  = 1'b0;
        sram_addr = row;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      num_pass_q <= 4'd0;
      relu_q     <= 1'b0;
      pass       <= 4'd0;
      row        <= '0;
      row_reg    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) err <= err_set;
      else if (err_set)           err <= 1'b1;

      case (state)
        IDLE: if (start) begin
          num_pass_q <= (num_pass == 4'd0) ? 4'd1 : num_pass;
          relu_q     <= relu_en;
          pass       <= 4'd0;
          row        <= '0;
          busy       <= 1'b1;
          state      <= ACC_FIRST;
        end
        ACC_FIRST: if (row_avail) begin
          if (row == LAST_ROW) begin
            row   <= '0;
            pass  <= 4'd1;
            state <= (num_pass_q == 4'd1) ? RO_RD : ACC_RD;
          end else begin
            row <= row + ADDR_W'(1);
          end
        end
        ACC_RD: if (row_avail) begin
          row_reg <= fifo_row;
          state   <= ACC_WR;
        end
        ACC_WR: begin
          if (row == LAST_ROW) begin
            row   <= '0;
            pass  <= pass_inc;
            state <= (pass_inc == num_pass_q) ? RO_RD : ACC_RD;
          end else begin
            row   <= row + ADDR_W'(1);
            state <= ACC_RD;
          end
        end
        RO_RD: state <= RO_WAIT;
        RO_WAIT: begin
          out_data  <= relu_row;
          out_valid <= 1'b1;
          state     <= RO_HOLD;
        end
        RO_HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          if (row == LAST_ROW) begin
            row   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            row   <= row + ADDR_W'(1);
            state <= RO_RD;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
